dmem_arbiter: RTL and testbench

- Sequences the single shared data memory port between two requesters: the MA stage (load/store) and a debug/loader port used to preload or inspect data memory.
- Converts the memory's variable-latency req/ack handshake into a pipeline stall for MA and a grant/response handshake for debug.
- Round-robin fair arbitration between the two requesters.
- Watchdog aborts any transaction the memory never acknowledges.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMaBusy  = 2'd1,
    StDbgBusy = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie, the requester not served last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_ma_i,
  input  logic req_dbg_i,
  input  logic done_i,      // a transaction completes this cycle
  input  logic done_dbg_i,  // ...and it was the debug one
  output logic pick_ma_o,
  output logic pick_dbg_o
);

  logic last_dbg_q, last_dbg_d;

  // Winner selection and last-served flag update.
  always_comb begin
    pick_dbg_o = req_dbg_i && (!req_ma_i || !last_dbg_q);
    pick_ma_o  = req_ma_i && !pick_dbg_o;
    last_dbg_d = done_i ? done_dbg_i : last_dbg_q;
  end

  // Last-served flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dbg_q <= 1'b0;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MA stage and a debug/loader port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ma_isLd,
  input  logic          ma_isSt,
  input  logic [AW-1:0] ma_addr,
  input  logic [DW-1:0] ma_wdata,
  output logic [DW-1:0] ma_rdata,
  output logic          ma_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

  dmem_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] ma_rdata_q, ma_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic          ma_req, busy, timeout, complete, ma_done, dbg_done;
  logic          pick_ma, pick_dbg;
  logic [DW-1:0] resp_data;

  // Load and store together is treated as no request.
  assign ma_req    = ma_isLd ^ ma_isSt;
  assign busy      = (state_q != StIdle);
  assign timeout   = busy && !mem_ack && (timer_q == TimerMax);
  assign complete  = busy && (mem_ack || timeout);
  assign ma_done   = (state_q == StMaBusy) && complete;
  assign dbg_done  = (state_q == StDbgBusy) && complete;
  // An aborted transaction returns zero.
  assign resp_data = mem_ack ? mem_rdata : '0;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_ma_i   (ma_req),
    .req_dbg_i  (dbg_req),
    .done_i     (complete),
    .done_dbg_i (state_q == StDbgBusy),
    .pick_ma_o  (pick_ma),
    .pick_dbg_o (pick_dbg)
  );

  // Next-state: grant in idle, count and finish in busy, capture read data.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    ma_rdata_d  = ma_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (pick_dbg) begin
          state_d     = StDbgBusy;
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
        end else if (pick_ma) begin
          state_d     = StMaBusy;
          mem_we_d    = ma_isSt;
          mem_addr_d  = ma_addr;
          mem_wdata_d = ma_wdata;
        end
      end
      StMaBusy, StDbgBusy: begin
        if (complete) begin
          state_d = StIdle;
          timer_d = '0;
          if (timeout) begin
            err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (ma_done && !mem_we_q) begin
      ma_rdata_d = resp_data;
    end
    if (dbg_done && !mem_we_q) begin
      dbg_rdata_d = resp_data;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      ma_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      ma_rdata_q  <= ma_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs; read data bypasses the register in the completion cycle.
  always_comb begin
    mem_req   = busy;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    err       = err_q;
    ma_stall  = ma_req && !ma_done;
    dbg_gnt   = dbg_done;
    ma_rdata  = (ma_done && !mem_we_q) ? resp_data : ma_rdata_q;
    dbg_rdata = (dbg_done && !mem_we_q) ? resp_data : dbg_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and completion scoreboard.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ma_isLd, ma_isSt;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata, ma_rdata;
  logic          ma_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_gnt;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          err;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ma_isLd   (ma_isLd),
    .ma_isSt   (ma_isSt),
    .ma_addr   (ma_addr),
    .ma_wdata  (ma_wdata),
    .ma_rdata  (ma_rdata),
    .ma_stall  (ma_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  // Memory model: ack in the ack_lat-th request cycle (0 = never), spur_ack forces ack.
  int          ack_lat = 1;
  bit          spur_ack = 1'b0;
  int          cnt = 0;
  logic [31:0] mem [0:255];

  assign mem_ack   = spur_ack || (mem_req && ack_lat != 0 && cnt == ack_lat - 1);
  assign mem_rdata = mem_ack ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  typedef struct {
    bit          is_dbg;
    bit          chk;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   st, bz, s1, s2, s3;
  exp_t mon_e;
  bit   mon_is_dbg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit d, input bit c, input logic [31:0] r);
    exp_t e;
    e.is_dbg = d;
    e.chk    = c;
    e.rd     = r;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every MA release or debug grant pops the next expected completion.
  always @(negedge clk) begin
    if (!rst && (((ma_isLd ^ ma_isSt) && !ma_stall) || dbg_gnt)) begin
      mon_is_dbg = dbg_gnt;
      n_checks++;
      assert (exp_q.size() != 0)
      else begin
        n_errors++;
        $error("FAIL unexpected_completion: observed dbg=%0d expected none", mon_is_dbg);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("completion_is_dbg", {31'b0, mon_is_dbg}, {31'b0, mon_e.is_dbg});
        if (mon_e.chk) begin
          if (mon_is_dbg) check("dbg_rdata", dbg_rdata, mon_e.rd);
          else            check("ma_rdata", ma_rdata, mon_e.rd);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge with MA idle.
  task automatic ma_op(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                       input bit chk_mem, output int stalls, output int busy);
    bit done = 1'b0;
    stalls = 0;
    busy = 0;
    ma_isLd = ld;
    ma_isSt = !ld;
    ma_addr = a;
    ma_wdata = wd;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (chk_mem && mem_req) begin
        busy++;
        check("mem_we", {31'b0, mem_we}, {31'b0, !ld});
        check("mem_addr", mem_addr, a);
        if (!ld) check("mem_wdata", mem_wdata, wd);
      end
      if (ma_stall) stalls++;
      else done = 1'b1;
    end
    n_checks++;
    assert (done)
    else begin
      n_errors++;
      $error("FAIL ma_release: observed stall after %0d cycles expected release", stalls);
    end
    step();
    ma_isLd = 1'b0;
    ma_isSt = 1'b0;
  endtask

  task automatic dbg_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    int waited = 0;
    dbg_req = 1'b1;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = wd;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (dbg_gnt) got = 1'b1;
    end
    n_checks++;
    assert (got)
    else begin
      n_errors++;
      $error("FAIL dbg_grant: observed no grant in %0d cycles expected grant", waited);
    end
    step();
    dbg_req = 1'b0;
    dbg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    ma_isLd = 1'b0; ma_isSt = 1'b0; ma_addr = '0; ma_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ma_stall", {31'b0, ma_stall}, 32'd0);
    check("rst_ma_rdata", ma_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    step();
    rst = 1'b0;

    // Preload through the debug port.
    push_exp(1'b1, 1'b0, 32'h0);
    dbg_op(1'b1, 32'h10, 32'hDEAD_BEEF);

    // Zero-wait MA load: one stall cycle.
    ack_lat = 1;
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF);
    ma_op(1'b1, 32'h10, 32'h0, 1'b1, st, bz);
    check("t1_stalls", st, 32'd1);
    check("t1_busy", bz, 32'd1);
    @(negedge clk);
    check("t1_rdata_held", ma_rdata, 32'hDEAD_BEEF);
    step();

    // MA store acked in the third busy cycle: three stalls, stable address/data.
    ack_lat = 3;
    push_exp(1'b0, 1'b0, 32'h0);
    ma_op(1'b0, 32'h20, 32'h1234_5678, 1'b1, st, bz);
    check("t2_stalls", st, 32'd3);
    check("t2_busy", bz, 32'd3);
    @(negedge clk);
    check("t2_rdata_unchanged", ma_rdata, 32'hDEAD_BEEF);
    step();
    ack_lat = 1;
    push_exp(1'b0, 1'b1, 32'h1234_5678);
    ma_op(1'b1, 32'h20, 32'h0, 1'b1, st, bz);
    check("t2_load_stalls", st, 32'd1);

    // Load and store together is no request; a stray ack in idle is ignored.
    ma_isLd = 1'b1;
    ma_isSt = 1'b1;
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_mem_req", {31'b0, mem_req}, 32'd0);
      check("t4_ma_stall", {31'b0, ma_stall}, 32'd0);
      check("t4_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    end
    step();
    ma_isLd = 1'b0;
    ma_isSt = 1'b0;
    spur_ack = 1'b0;

    // Contention from reset: debug first, then strict alternation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_exp(1'b1, 1'b1, 32'h1234_5678);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF);
    push_exp(1'b1, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, 32'hCAFE_F00D);
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF);
    push_exp(1'b0, 1'b0, 32'h0);
    fork
      begin
        ma_op(1'b1, 32'h10, 32'h0, 1'b0, s1, bz);
        ma_op(1'b1, 32'h30, 32'h0, 1'b0, s2, bz);
        ma_op(1'b0, 32'h40, 32'hA5A5_A5A5, 1'b0, s3, bz);
      end
      begin
        dbg_op(1'b0, 32'h20, 32'h0);
        dbg_op(1'b1, 32'h30, 32'hCAFE_F00D);
        dbg_op(1'b0, 32'h10, 32'h0);
      end
    join
    check("t3_stalls_1", s1, 32'd3);
    check("t3_stalls_2", s2, 32'd3);
    check("t3_stalls_3", s3, 32'd3);
    @(negedge clk);
    check("t3_dbg_rdata_held", dbg_rdata, 32'hDEAD_BEEF);
    step();

    // Memory never acks: abort in the 16th busy cycle, sticky error.
    ack_lat = 0;
    push_exp(1'b0, 1'b1, 32'h0);
    ma_op(1'b1, 32'h10, 32'h0, 1'b1, st, bz);
    check("t5_stalls", st, TIMEOUT);
    check("t5_busy", bz, TIMEOUT);
    @(negedge clk);
    check("t5_err", {31'b0, err}, 32'd1);
    check("t5_rdata_zero", ma_rdata, 32'd0);
    step();
    ack_lat = 1;
    push_exp(1'b0, 1'b1, 32'h1234_5678);
    ma_op(1'b1, 32'h20, 32'h0, 1'b1, st, bz);
    check("t5_next_stalls", st, 32'd1);
    @(negedge clk);
    check("t5_err_sticky", {31'b0, err}, 32'd1);
    step();

    // Reset in the middle of a busy MA access; held request restarts after reset.
    ack_lat = 0;
    push_exp(1'b0, 1'b1, 32'h1234_5678);
    ma_isLd = 1'b1;
    ma_isSt = 1'b0;
    ma_addr = 32'h20;
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", {31'b0, mem_req}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_lat = 1;
    @(negedge clk);
    check("t6_mem_req", {31'b0, mem_req}, 32'd0);
    check("t6_mem_addr", mem_addr, 32'd0);
    check("t6_err", {31'b0, err}, 32'd0);
    check("t6_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("t6_ma_stall", {31'b0, ma_stall}, 32'd1);
    @(negedge clk);
    check("t6_restart_req", {31'b0, mem_req}, 32'd1);
    check("t6_restart_stall", {31'b0, ma_stall}, 32'd0);
    step();
    ma_isLd = 1'b0;
    step();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
